// File: rtl/instr_issue_unit.sv
// Instruction issue stage: buffers instructions in a FIFO and inserts bubbles
// whenever the FIFO head reads a register still owned by an in-flight producer.
module instr_issue_unit #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned HAZARD_WINDOW = 3
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        InstrValid,
    input  logic [31:0]                 InstrData,
    output logic                        InstrReady,
    output logic [31:0]                 InstrOut,
    output logic                        IssueValid,
    output logic [15:0]                 StallCount,
    output logic [$clog2(FIFO_DEPTH):0] FifoCount
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned SB_N  = HAZARD_WINDOW - 1;
    localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [SB_N-1:0]  sb_valid;
    logic [4:0]       sb_rd [SB_N];

    logic [31:0] head;
    logic        reads_rs;
    logic        reads_rt;
    logic        writes_rd;
    logic        hazard;
    logic        non_empty;
    logic        full;
    logic        push;
    logic        pop;

    assign head      = mem[rd_ptr];
    assign non_empty = (count != '0);
    assign full      = (count == FULL_CNT);
    assign InstrReady = Reset && !full;
    assign push      = InstrValid && InstrReady;
    assign pop       = non_empty && !hazard;
    assign FifoCount = count;

    // R-type reads rs/rt (NOT reads rs only); I-type reads rs; others touch nothing.
    always_comb begin
        reads_rs  = 1'b0;
        reads_rt  = 1'b0;
        writes_rd = 1'b0;
        if (head[31:29] == 3'b010) begin
            reads_rs  = 1'b1;
            reads_rt  = (head[31:26] != 6'b010001);
            writes_rd = 1'b1;
        end else if (head[31:29] == 3'b011) begin
            reads_rs  = 1'b1;
            writes_rd = 1'b1;
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < SB_N; i++) begin
            if (sb_valid[i] &&
                ((reads_rs && (sb_rd[i] == head[20:16])) ||
                 (reads_rt && (sb_rd[i] == head[15:11]))))
                hazard = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (push)
            mem[wr_ptr] <= InstrData;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            InstrOut   <= '0;
            IssueValid <= 1'b0;
            StallCount <= '0;
            sb_valid   <= '0;
            for (int unsigned i = 0; i < SB_N; i++)
                sb_rd[i] <= '0;
        end else begin
            for (int unsigned i = SB_N - 1; i > 0; i--) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
            sb_valid[0] <= pop && writes_rd;
            sb_rd[0]    <= head[25:21];
            if (pop) begin
                InstrOut   <= head;
                IssueValid <= 1'b1;
            end else begin
                InstrOut   <= '0;
                IssueValid <= 1'b0;
            end
            if (non_empty && hazard && (StallCount != 16'hFFFF))
                StallCount <= StallCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench for instr_issue_unit: per-cycle vector table plus hand-written
// sequences for reset, full-FIFO ordering and mid-operation reset.
module tb_instr_issue_unit;
    logic        Clk;
    logic        Reset;
    logic        InstrValid;
    logic [31:0] InstrData;
    logic        InstrReady;
    logic [31:0] InstrOut;
    logic        IssueValid;
    logic [15:0] StallCount;
    logic [2:0]  FifoCount;

    int total = 0;
    int bad   = 0;

    instr_issue_unit #(.FIFO_DEPTH(4), .HAZARD_WINDOW(3)) dut (
        .Clk(Clk), .Reset(Reset), .InstrValid(InstrValid), .InstrData(InstrData),
        .InstrReady(InstrReady), .InstrOut(InstrOut), .IssueValid(IssueValid),
        .StallCount(StallCount), .FifoCount(FifoCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [31:0] out;
        logic        iv;
        logic [2:0]  cnt;
        logic [15:0] st;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic row(input logic v, input logic [31:0] d, input logic [31:0] out,
                       input logic iv, input logic [2:0] cnt, input logic [15:0] st);
        vec_t r;
        r.v = v; r.d = d; r.out = out; r.iv = iv; r.cnt = cnt; r.st = st;
        tbl.push_back(r);
    endtask

    // Assert reset at mid-cycle, release at a later mid-cycle, return at posedge+1.
    task automatic do_reset();
        InstrValid = 1'b0;
        InstrData  = '0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    localparam logic [31:0] ADDI1 = 32'h6821000A;
    localparam logic [31:0] ORI2  = 32'h70420002;
    localparam logic [31:0] ADD3  = 32'h48611000;
    localparam logic [31:0] ANDI5 = 32'h74A5FFFF;
    localparam logic [31:0] NOT7  = 32'h44E12800;
    localparam logic [31:0] ADD5  = 32'h48A52800;

    initial begin
        Reset      = 1'b0;
        InstrValid = 1'b0;
        InstrData  = '0;

        // Reset state while held low
        #12;
        chk("rst_out",   InstrOut,   32'h0);
        chk("rst_iv",    {31'b0, IssueValid}, 32'h0);
        chk("rst_ready", {31'b0, InstrReady}, 32'h0);
        chk("rst_cnt",   {29'b0, FifoCount},  32'h0);
        chk("rst_stall", {16'b0, StallCount}, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk("rel_ready", {31'b0, InstrReady}, 32'h1);
        chk("rel_cnt",   {29'b0, FifoCount},  32'h0);

        // Mid-stream asynchronous reset: outputs clear without an edge
        InstrValid = 1'b1; InstrData = ADDI1;
        @(posedge Clk); #1;
        InstrData = ORI2;
        @(posedge Clk); #1;
        InstrValid = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        chk("async_out",   InstrOut,   32'h0);
        chk("async_iv",    {31'b0, IssueValid}, 32'h0);
        chk("async_ready", {31'b0, InstrReady}, 32'h0);
        chk("async_cnt",   {29'b0, FifoCount},  32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk("async_rel_ready", {31'b0, InstrReady}, 32'h1);
        chk("async_rel_cnt",   {29'b0, FifoCount},  32'h0);

        // Table: independent pair, RAW stall, field-selective decode
        row(1, ADDI1, 32'h0, 0, 1, 0);
        row(1, ORI2,  ADDI1, 1, 1, 0);
        row(0, 0,     ORI2,  1, 0, 0);
        row(0, 0,     32'h0, 0, 0, 0);
        row(0, 0,     32'h0, 0, 0, 0);
        row(0, 0,     32'h0, 0, 0, 0);
        row(1, ADDI1, 32'h0, 0, 1, 0);
        row(1, ORI2,  ADDI1, 1, 1, 0);
        row(1, ADD3,  ORI2,  1, 1, 0);
        row(0, 0,     32'h0, 0, 1, 1);
        row(0, 0,     32'h0, 0, 1, 2);
        row(0, 0,     ADD3,  1, 0, 2);
        row(0, 0,     32'h0, 0, 0, 2);
        row(1, ANDI5, 32'h0, 0, 1, 2);
        row(1, NOT7,  ANDI5, 1, 1, 2);
        row(0, 0,     NOT7,  1, 0, 2);
        row(0, 0,     32'h0, 0, 0, 2);
        row(0, 0,     32'h0, 0, 0, 2);
        row(0, 0,     32'h0, 0, 0, 2);
        row(1, ANDI5, 32'h0, 0, 1, 2);
        row(1, ADD5,  ANDI5, 1, 1, 2);
        row(0, 0,     32'h0, 0, 1, 3);
        row(0, 0,     32'h0, 0, 1, 4);
        row(0, 0,     ADD5,  1, 0, 4);
        row(0, 0,     32'h0, 0, 0, 4);

        do_reset();
        foreach (tbl[i]) begin
            InstrValid = tbl[i].v;
            InstrData  = tbl[i].d;
            @(posedge Clk); #1;
            chk($sformatf("row%0d_out", i),   InstrOut, tbl[i].out);
            chk($sformatf("row%0d_iv", i),    {31'b0, IssueValid}, {31'b0, tbl[i].iv});
            chk($sformatf("row%0d_cnt", i),   {29'b0, FifoCount},  {29'b0, tbl[i].cnt});
            chk($sformatf("row%0d_stall", i), {16'b0, StallCount}, {16'b0, tbl[i].st});
            chk($sformatf("row%0d_ready", i), {31'b0, InstrReady}, 32'h1);
        end

        // Six dependent ADDI R1,R1,k: ordering, spacing, full flag, stall total
        do_reset();
        begin
            int pushed = 0;
            int issued = 0;
            int last_cyc = 0;
            bit saw_full = 0;
            logic rdy;
            for (int cyc = 1; cyc <= 60 && issued < 6; cyc++) begin
                InstrValid = (pushed < 6);
                InstrData  = 32'h68210001 + pushed;
                #4;
                rdy = InstrReady;
                if (FifoCount == 3'd4) saw_full = 1;
                if (rdy !== (FifoCount != 3'd4)) begin
                    chk("full_ready", {31'b0, rdy}, {31'b0, (FifoCount != 3'd4)});
                end
                @(posedge Clk); #1;
                if (InstrValid && rdy) pushed++;
                if (FifoCount == 3'd4) saw_full = 1;
                if (IssueValid) begin
                    issued++;
                    chk($sformatf("seq_issue%0d", issued), InstrOut, 32'h68210000 + issued);
                    if (issued > 1)
                        chk($sformatf("seq_gap%0d", issued), cyc - last_cyc, 3);
                    last_cyc = cyc;
                end
            end
            chk("seq_issued", issued, 6);
            chk("seq_pushed", pushed, 6);
            chk("seq_saw_full", {31'b0, saw_full}, 32'h1);
            chk("seq_ready_at_full", {31'b0, InstrReady}, {31'b0, (FifoCount != 3'd4)});
            @(posedge Clk); #1;
            chk("seq_stall", {16'b0, StallCount}, 32'd10);
            chk("seq_cnt",   {29'b0, FifoCount},  32'd0);
        end

        // Reset with three queued entries and a stall pending
        do_reset();
        InstrValid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            InstrData = 32'h6821F000 + k;
            @(posedge Clk); #1;
        end
        InstrValid = 1'b0;
        chk("mid_cnt_before", {29'b0, FifoCount}, 32'd3);
        #2;
        Reset = 1'b0;
        #1;
        chk("mid_cnt_low",   {29'b0, FifoCount},  32'd0);
        chk("mid_stall_low", {16'b0, StallCount}, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge Clk); #1;
            chk($sformatf("mid_out%0d", k), InstrOut, 32'h0);
            chk($sformatf("mid_iv%0d", k),  {31'b0, IssueValid}, 32'h0);
        end
        chk("mid_cnt_after",   {29'b0, FifoCount},  32'd0);
        chk("mid_stall_after", {16'b0, StallCount}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
